// File: rtl/rom_scan_pkg.sv
// Shared types, limits and helpers for the ROM scan harness.
package rom_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOK,
        ST_SHIFT,
        ST_DONE
    } state_t;

    localparam int ADDR_W_MIN = 5;
    localparam int ADDR_W_MAX = 8;
    localparam int N_CH_MIN   = 1;
    localparam int N_CH_MAX   = 64;

    // Number of one-bit entries in a lane of the given address width.
    function automatic int depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/rom_scan_lane.sv
// One distributed-ROM lane: a 32/64/128/256 x 1 asynchronous ROM chosen by ADDR_W.
module rom_scan_lane
    import rom_scan_pkg::*;
#(
    parameter int                         ADDR_W = 7,
    parameter logic [depth(ADDR_W)-1:0]   INIT   = '0
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              data
);

    // NOTE: the contents are elaboration-time constants, so the ROM has no reset and no clock.
    generate
        case (ADDR_W)
            5: begin : g_rom32x1
                logic [31:0] rom32;
                assign rom32 = INIT;
                assign data  = rom32[addr];
            end
            6: begin : g_rom64x1
                logic [63:0] rom64;
                assign rom64 = INIT;
                assign data  = rom64[addr];
            end
            7: begin : g_rom128x1
                logic [127:0] rom128;
                assign rom128 = INIT;
                assign data   = rom128[addr];
            end
            8: begin : g_rom256x1
                logic [255:0] rom256;
                assign rom256 = INIT;
                assign data   = rom256[addr];
            end
            default: begin : g_rom_none
                assign data = 1'b0;
            end
        endcase
    endgenerate

endmodule

// File: rtl/rom_scan_harness.sv
// Serial-in address / serial-out result harness around N_CH ROM lanes,
// with a busy/done handshake and a sticky overrun flag.
module rom_scan_harness
    import rom_scan_pkg::*;
#(
    parameter int                           N_CH   = 8,
    parameter int                           ADDR_W = 7,
    parameter logic [(N_CH<<ADDR_W)-1:0]    INIT   = '0
) (
    input  logic clk,
    input  logic rst,
    input  logic di,
    input  logic stb,
    output logic dout,      // serial result, lane N_CH-1 first
    output logic busy,
    output logic done,
    output logic overrun
);

    localparam int                DEPTH    = depth(ADDR_W);
    localparam int                ADDR_TOT = N_CH * ADDR_W;
    localparam int                CNT_W    = $clog2(N_CH) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N_CH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    generate
        if (ADDR_W < ADDR_W_MIN || ADDR_W > ADDR_W_MAX ||
            N_CH < N_CH_MIN || N_CH > N_CH_MAX) begin : g_param_check
            $error("rom_scan_harness: unsupported N_CH=%0d ADDR_W=%0d", N_CH, ADDR_W);
        end
    endgenerate

    state_t               state, state_nxt;
    logic [ADDR_TOT-1:0]  din_shr;
    logic [ADDR_TOT-1:0]  addr;
    logic [N_CH-1:0]      lane_bits;
    logic [N_CH-1:0]      dout_shr;
    logic [CNT_W-1:0]     cnt;

    // One ROM lane per channel, each addressed by its own slice of the captured address.
    generate
        for (genvar c = 0; c < N_CH; c++) begin : g_lane
            rom_scan_lane #(
                .ADDR_W (ADDR_W),
                .INIT   (INIT[c*DEPTH +: DEPTH])
            ) u_lane (
                .addr (addr[c*ADDR_W +: ADDR_W]),
                .data (lane_bits[c])
            );
        end
    endgenerate

    // Address shift register: shifts every cycle in every state, di into bit 0.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            din_shr <= '0;
        end else begin
            din_shr <= {din_shr[ADDR_TOT-2:0], di};
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and the done pulse.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            ST_IDLE:  if (stb) state_nxt = ST_LOOK;
            ST_LOOK:  state_nxt = ST_SHIFT;
            ST_SHIFT: if (cnt == '0) state_nxt = ST_DONE;
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Capture, load, serialise and flag bookkeeping driven by the current state.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr     <= '0;
            dout_shr <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (stb && state != ST_IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (stb) begin
                        addr <= din_shr;
                        busy <= 1'b1;
                    end
                end
                ST_LOOK: begin
                    dout_shr <= lane_bits;
                    cnt      <= CNT_LAST;
                end
                ST_SHIFT: begin
                    dout_shr <= dout_shr << 1;
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_DONE: busy <= 1'b0;
                default: ;
            endcase
        end
    end

    assign dout = dout_shr[N_CH-1];

endmodule
